ti_cic_decim_param: RTL

//  Parametrised successor to the fixed 4-lane, 8x2 time-interleaved CIC filter.

---
 rtl/ti_cic_decim_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ti_cic_decim_param.sv
// Time-interleaved CIC decimator, parametrised.
// One parallel word of LANES interleaved samples arrives per clock. The lanes
// are summed (polyphase boxcar of length LANES), then fed to an ORDER-stage CIC
// decimator whose ratio R_act (1..RMAX) is reloaded from DEC at group boundaries.
// Every pipeline stage carries a valid tag so idle cycles neither stall the
// pipeline nor inject zeros; the latency from the last accepted sample of a group
// to OUT_VALID is always 2*ORDER cycles.
module ti_cic_decim_param #(
    parameter int BW    = 6,
    parameter int LANES = 4,
    parameter int ORDER = 3,
    parameter int RMAX  = 16,
    parameter int DW    = $clog2(RMAX) + 1,
    parameter int OW    = BW + $clog2(LANES) + ORDER * $clog2(RMAX)
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  ENABLE,
    input  logic                  SYNC_CLR,
    input  logic                  IN_VALID,
    input  logic [LANES*BW-1:0]   IN,
    input  logic [DW-1:0]         DEC,
    output logic [OW-1:0]         OUT,
    output logic                  OUT_VALID
);

    // ------------------------------------------------------------------
    // Ratio clamp: 0 behaves as 1, anything above RMAX behaves as RMAX.
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] clamp_ratio(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (d == '0)
            r = DW'(1);
        else if (d > DW'(RMAX))
            r = DW'(RMAX);
        return r;
    endfunction

    // Front end: lane sum register and its valid tag
    logic [OW-1:0]     lane_sum;
    logic              accept;
    logic [OW-1:0]     s_reg;

    // Integrator chain; itag[k] marks a valid input for stage k+1
    logic [OW-1:0]     integ    [1:ORDER];
    logic [OW-1:0]     integ_in [1:ORDER];
    logic [ORDER-1:0]  itag;

    // Decimation counter and active ratio
    logic [DW-1:0]     cnt;
    logic [DW-1:0]     r_act;

    // Comb chain; ctag[k] marks a valid input for comb stage k+1
    logic [OW-1:0]     comb_q    [1:ORDER];
    logic [OW-1:0]     comb_prev [1:ORDER];
    logic [OW-1:0]     comb_in   [1:ORDER];
    logic [ORDER-1:0]  ctag;

    assign accept = IN_VALID & ENABLE;

    // Sum all lanes, each sign-extended to the full output width.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + OW'($signed(IN[k*BW +: BW]));
        end
    end

    // Stage input selection for the integrator and comb chains.
    always_comb begin
        integ_in[1] = s_reg;
        comb_in[1]  = integ[ORDER];
        for (int k = 2; k <= ORDER; k++) begin
            integ_in[k] = integ[k-1];
            comb_in[k]  = comb_q[k-1];
        end
    end

    // Lane-sum register and integrator chain: each stage accumulates only when
    // its input tag is set; tags advance one stage per clock.
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's value from before this edge, giving a true pipeline.
    // NOTE: the register arrays are cleared explicitly on reset and clear; a
    // partial group must never leak into the results after a restart.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            s_reg <= '0;
            itag  <= '0;
            for (int k = 1; k <= ORDER; k++) integ[k] <= '0;
        end else if (SYNC_CLR) begin
            s_reg <= '0;
            itag  <= '0;
            for (int k = 1; k <= ORDER; k++) integ[k] <= '0;
        end else begin
            itag[0] <= accept;
            if (accept) s_reg <= lane_sum;
            for (int k = 1; k < ORDER; k++) itag[k] <= itag[k-1];
            for (int k = 1; k <= ORDER; k++) begin
                if (itag[k-1]) integ[k] <= integ[k] + integ_in[k];
            end
        end
    end

    // Decimation counter, ratio reload at group boundaries, comb chain and output strobe.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            cnt       <= '0;
            r_act     <= DW'(1);
            ctag      <= '0;
            OUT_VALID <= 1'b0;
            for (int k = 1; k <= ORDER; k++) begin
                comb_q[k]    <= '0;
                comb_prev[k] <= '0;
            end
        end else if (SYNC_CLR) begin
            cnt       <= '0;
            r_act     <= DW'(1);
            ctag      <= '0;
            OUT_VALID <= 1'b0;
            for (int k = 1; k <= ORDER; k++) begin
                comb_q[k]    <= '0;
                comb_prev[k] <= '0;
            end
        end else begin
            ctag[0] <= 1'b0;
            // The last integrator is updated on this same edge; the launch tag
            // lets the first comb pick up that new value on the next edge.
            if (itag[ORDER-1]) begin
                if (cnt == r_act - DW'(1)) begin
                    cnt     <= '0;
                    r_act   <= clamp_ratio(DEC);
                    ctag[0] <= 1'b1;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
            for (int k = 1; k < ORDER; k++) ctag[k] <= ctag[k-1];
            for (int k = 1; k <= ORDER; k++) begin
                if (ctag[k-1]) begin
                    comb_q[k]    <= comb_in[k] - comb_prev[k];
                    comb_prev[k] <= comb_in[k];
                end
            end
            OUT_VALID <= ctag[ORDER-1];
        end
    end

    // The last comb register only changes on a strobe, so OUT holds between strobes.
    assign OUT = comb_q[ORDER];

endmodule
